// File: rtl/fsm_step_responder.sv
// fsm_step_responder: drives A into the step FSM and checks its {b,c,d} code sequence; RESP_TIMEOUT_EN adds an ARM timeout
module fsm_step_responder #(
  parameter int PAT_W   = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [2:0]       code,
  output logic             A,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [2:0]       exp_code,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] loop_count
);
  if ((1 << LEN_W) <= PAT_W || TIMEOUT < 1) begin : g_bad_cfg
    $error("fsm_step_responder: LEN_W too narrow for PAT_W or TIMEOUT < 1");
  end
  typedef enum logic [2:0] {IDLE, ARM, SYNC, DECIDE, LOOP, TERM, ERR} state_t;
  state_t state_q, state_d;
  logic [PAT_W-1:0] sr_q, sr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] loop_q, loop_d;
  logic [2:0] exp_q, exp_d, err_q, err_d, want;
  logic last_q, last_d, a_q, a_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic take, consume, mis, expire;
`ifdef RESP_TIMEOUT_EN
  localparam int T_W = $clog2(TIMEOUT + 1);
  logic [T_W-1:0] tmo_q, tmo_d;
`endif
  // next-state: start wins in IDLE/TERM/ERR, then ARM handling, mismatch, consuming 010, DECIDE outcome
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    rem_d = rem_q;
    last_d = last_q;
    loop_d = loop_q;
    done_d = done_q;
    error_d = error_q;
    exp_d = exp_q;
    err_d = err_q;
    take = start && (state_q == IDLE || state_q == TERM || state_q == ERR);
    want = state_q == DECIDE ? (last_q ? 3'b110 : 3'b111) : state_q == TERM ? 3'b111 : 3'b010;
    consume = (state_q == SYNC || state_q == LOOP) && code == 3'b010;
    mis = (state_q inside {SYNC, DECIDE, LOOP, TERM}) && code != want;
`ifdef RESP_TIMEOUT_EN
    tmo_d = take ? '0 : state_q == ARM ? tmo_q + 1'b1 : tmo_q;
    expire = tmo_q == T_W'(TIMEOUT - 1);
`else
    expire = 1'b0;
`endif
    if (take) begin
      sr_d = pattern;
      rem_d = pat_len > LEN_W'(PAT_W) ? LEN_W'(PAT_W) : pat_len;
      loop_d = '0;
      done_d = 1'b0;
      error_d = 1'b0;
      exp_d = 3'b000;
      err_d = 3'b000;
      state_d = ARM;
    end else if (state_q == ARM) begin
      if (code == 3'b101) state_d = SYNC;
      else if (code != 3'b000 || expire) begin
        state_d = ERR;
        exp_d = 3'b101;
        err_d = code;
        error_d = 1'b1;
      end
    end else if (mis) begin
      state_d = ERR;
      exp_d = want;
      err_d = code;
      error_d = 1'b1;
    end else if (consume) begin
      state_d = DECIDE;
      last_d = a_q;
      sr_d = sr_q >> 1;
      rem_d = rem_q - LEN_W'(rem_q != '0);
    end else if (state_q == DECIDE) begin
      state_d = last_q ? LOOP : TERM;
      loop_d = last_q ? (&loop_q ? loop_q : loop_q + 1'b1) : loop_q;
      done_d = !last_q;
    end
    a_d = rem_d != '0 && sr_d[0];
    busy_d = state_d inside {ARM, SYNC, DECIDE, LOOP};
  end
  // all state and registered outputs; asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q <= '0;
      rem_q <= '0;
      last_q <= 1'b0;
      loop_q <= '0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      exp_q <= 3'b000;
      err_q <= 3'b000;
      a_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef RESP_TIMEOUT_EN
      tmo_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      rem_q <= rem_d;
      last_q <= last_d;
      loop_q <= loop_d;
      done_q <= done_d;
      error_q <= error_d;
      exp_q <= exp_d;
      err_q <= err_d;
      a_q <= a_d;
      busy_q <= busy_d;
`ifdef RESP_TIMEOUT_EN
      tmo_q <= tmo_d;
`endif
    end
  end
  assign A = a_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = error_q;
  assign exp_code = exp_q;
  assign err_code = err_q;
  assign loop_count = loop_q;
endmodule

// File: tb/tb_fsm_step_responder.sv
// tb_fsm_step_responder: directed checks of the step responder against hand-computed values
module tb_fsm_step_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0] pat_len = '0;
  logic [2:0] code = 3'b000;
  logic A, busy, done, error;
  logic [2:0] exp_code, err_code;
  logic [7:0] loop_count;
  int n_chk = 0;
  int n_pass = 0;
  fsm_step_responder dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .pat_len(pat_len),
    .code(code), .A(A), .busy(busy), .done(done), .error(error),
    .exp_code(exp_code), .err_code(err_code), .loop_count(loop_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
  endtask
  task automatic tick(input logic [2:0] c);
    code = c;
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [15:0] p, input logic [4:0] l, input logic [2:0] c);
    pattern = p;
    pat_len = l;
    start = 1'b1;
    tick(c);
    start = 1'b0;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_out"}, {A, busy, done, error, exp_code, err_code, loop_count}, 0);
  endtask
  initial begin
    #12 all_zero("reset");
    reset = 1'b1;
    tick(3'b000);
    all_zero("idle");
    go(16'b0011, 5'd2, 3'b000);
    chk("t1_busy", busy, 1);
    chk("t1_a0", A, 1);
    repeat (3) tick(3'b000);
    chk("t1_arm_wait", {busy, error}, 2'b10);
    tick(3'b101);
    pattern = 16'h0000;
    pat_len = 5'd0;
    start = 1'b1;
    tick(3'b010);
    start = 1'b0;
    chk("t1_start_ignored_a", A, 1);
    tick(3'b110);
    chk("t1_loop1", loop_count, 1);
    tick(3'b010);
    chk("t1_a_after_2nd_shift", A, 0);
    tick(3'b110);
    tick(3'b010);
    tick(3'b111);
    chk("t1_term", {done, error, busy}, 3'b100);
    chk("t1_loops", loop_count, 2);
    repeat (3) tick(3'b111);
    chk("t1_hold", {done, error}, 2'b10);
    go(16'hFFFF, 5'd0, 3'b000);
    chk("t2_start", {busy, done, A}, 3'b100);
    chk("t2_loops", loop_count, 0);
    tick(3'b101);
    tick(3'b010);
    chk("t2_a", A, 0);
    tick(3'b111);
    chk("t2_done", {done, error, busy}, 3'b100);
    chk("t2_loops_end", loop_count, 0);
    go(16'hFFFF, 5'd20, 3'b000);
    tick(3'b101);
    tick(3'b010);
    for (int i = 0; i < 16; i++) begin
      tick(3'b110);
      tick(3'b010);
    end
    chk("t3_a_exhausted", A, 0);
    chk("t3_busy", busy, 1);
    tick(3'b111);
    chk("t3_done", {done, error}, 2'b10);
    chk("t3_loops", loop_count, 16);
    go(16'h0001, 5'd1, 3'b000);
    tick(3'b101);
    tick(3'b010);
    tick(3'b110);
    tick(3'b111);
    chk("t4_err", {error, busy, done}, 3'b100);
    chk("t4_exp", exp_code, 3'b010);
    chk("t4_got", err_code, 3'b111);
    go(16'h0001, 5'd1, 3'b010);
    chk("t4_restart", {error, busy}, 2'b01);
    chk("t4_clr_codes", {exp_code, err_code}, 0);
    tick(3'b111);
    chk("t4_arm_illegal", {error, exp_code, err_code}, {1'b1, 3'b101, 3'b111});
    go(16'h0001, 5'd1, 3'b000);
    tick(3'b101);
    tick(3'b010);
    chk("t5_in_decide", {busy, A}, 2'b10);
    reset = 1'b0;
    #1 all_zero("t5_async");
    @(posedge clk);
    #1 all_zero("t5_held");
    reset = 1'b1;
    tick(3'b101);
    tick(3'b010);
    chk("t5_idle", {busy, error, done}, 0);
    go(16'h0000, 5'd0, 3'b000);
    repeat (63) tick(3'b000);
    chk("t6_pre", {error, busy}, 2'b01);
    tick(3'b000);
`ifdef RESP_TIMEOUT_EN
    chk("t6_timeout", {error, busy}, 2'b10);
    chk("t6_codes", {exp_code, err_code}, {3'b101, 3'b000});
`else
    repeat (6) tick(3'b000);
    chk("t6_no_timeout", {error, busy}, 2'b01);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fsm_step_responder.md
# fsm_step_responder

- Drives the `A` input of the team's four-state step FSM and checks the 3-bit code `{b,c,d}` that the FSM returns each cycle.
- Replays a host-loaded decision pattern on `A`, one bit per FSM decision.
- Tracks the legal code sequence, counts loops and flags the first illegal code.
- Sits beside the step FSM in the lab harness; the host (switches/testbench) starts it.

## Interface
Parameters:
- PAT_W, 16, decision pattern depth in bits
- LEN_W, 5, width of pat_len; 2^LEN_W > PAT_W required
- CNT_W, 8, loop counter width
- TIMEOUT, 64, arm-timeout cycles (used only with RESP_TIMEOUT_EN)

Ports:
- clk  in  1  clock; reset reset, asynchronous, active-low
- reset  in  1  asynchronous active-low reset
- start  in  1  load pattern and arm; single-cycle pulse
- pattern  in  PAT_W  decision bits, bit 0 consumed first
- pat_len  in  LEN_W  number of decisions to drive; values > PAT_W clamp to PAT_W
- code  in  3  peer FSM output {b,c,d}
- A  out  1  decision bit to peer, registered
- busy  out  1  high from arm until done or error
- done  out  1  sticky, peer reached terminal code 3'b111
- error  out  1  sticky, illegal code observed
- exp_code  out  3  expected code at the error
- err_code  out  3  observed code at the error
- loop_count  out  CNT_W  number of 3'b110 codes seen, saturating

## Operation
- Legal peer code sequence: 000 (in reset) → 101 → 010 → 110 (A was 1) or 111 (A was 0). 110 → 010. 111 holds forever.
- States: IDLE, ARM, SYNC, DECIDE, LOOP, TERM, ERR.
- IDLE: `busy`=0. On `start`:
  - load the shift register from `pattern` and `remaining` from the clamped `pat_len`;
  - clear `loop_count`, `done`, `error`, `exp_code` and `err_code`;
  - go to ARM.
- ARM: code 000 → stay. Code 101 → SYNC. Other codes → ERR with exp_code=101.
- SYNC (expects 010): code 010 → DECIDE, latch `last_bit`=A, and shift.
- Shift means: shift register right by 1, `remaining`-=1 if nonzero.
- DECIDE: expects 110 if `last_bit`=1, else 111.
  - 110 → LOOP, `loop_count`+1 (saturating at all-ones).
  - 111 → TERM.
- LOOP (expects 010): code 010 → DECIDE, latch `last_bit`, and shift.
- TERM: `done`=1, `busy`=0. Code 111 → stay. Any other code → ERR with exp_code=111; `done` stays 1.
- Any mismatch in SYNC/DECIDE/LOOP/TERM → ERR.
  - Latch `exp_code` and `err_code` (the observed code).
  - `error`=1, `busy`=0.
- A code of 000 in any tracking state is a mismatch (peer was reset).
- A = sr[0] when `remaining`>0, else 0. An exhausted pattern forces the peer to terminal 111.
- `start` is accepted only in IDLE, TERM and ERR. In ARM/SYNC/DECIDE/LOOP it is ignored.
- `pattern` and `pat_len` are sampled only on an accepted `start`.

## Timing
- Reset values:
  - state IDLE;
  - A=0, busy=0, done=0, error=0;
  - exp_code=000, err_code=000, loop_count=0.
  - The shift register and `remaining` are also reset to 0.
- Reset mid-operation returns to IDLE immediately and clears all outputs.
- `start` at edge n → busy=1 and A=pattern[0] (if pat_len>0) from cycle n+1.
- The shift happens at the end of each cycle in which a consuming 010 is seen. The new A is valid on the next cycle, before the peer samples it during 110.
- A is stable for the whole 101/110 cycle in which the peer samples it.
- State, error, done and loop_count update one cycle after the triggering code (registered compare).
- `start` and a code event in the same cycle while in TERM/ERR: `start` wins; the code is ignored that cycle.

## Configuration
- `RESP_TIMEOUT_EN` defined:
  - a counter runs while in ARM;
  - if 101 is not seen within TIMEOUT cycles of arming, go to ERR with exp_code=101, err_code=code at expiry.
- Without it: ARM waits indefinitely and TIMEOUT is unused.

## Test plan
- pattern=16'b0011, pat_len=2; peer released after 3 cycles. Expect:
  - codes 101,010,110,010,110,010,111;
  - loop_count=2, done=1, error=0, A=0 after the 2nd shift.
- pat_len=0. Expect A=0 throughout, codes 101,010,111, done=1, loop_count=0.
- pat_len=20 with all-ones pattern (clamp to 16). Expect exactly 16 loops, then 111, done=1.
- In LOOP, force code=111 instead of 010. Expect error=1, exp_code=010, err_code=111, busy=0. A later `start` clears error.
- Pulse reset during DECIDE. Expect all outputs 0 next cycle and state IDLE.
- With RESP_TIMEOUT_EN and code held 000 for 70 cycles after `start`: error at cycle 65, exp_code=101, err_code=000. Without the macro: no error.
